// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds
// and selectable first-word-fall-through read mode. Optional OVF/UDF sticky flags under FIFO_ERR_FLAGS_EN.
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic                   W_EN,
  input  logic [WIDTH-1:0]       W_DI,
  input  logic                   REN,
  output logic [WIDTH-1:0]       R_DO,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   AFULL,
  output logic                   AEMPTY,
  output logic [$clog2(DEPTH):0] COUNT
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                   OVF,
  output logic                   UDF,
  input  logic                   ERR_CLR
`endif
);

  localparam int ADDRW = $clog2(DEPTH);
  localparam int CNTW  = ADDRW + 1;
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AFULL_C   = CNTW'(AFULL_TH);
  localparam logic [CNTW-1:0] AEMPTY_C  = CNTW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDRW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             wr_acc, rd_acc;

  // Requests are qualified only by registered flags, so no full pass-through or empty bypass.
  always_comb begin
    wr_acc  = W_EN && !FULL;
    rd_acc  = REN && !EMPTY;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[wptr_q[ADDRW-1:0]] <= W_DI;
  end

  assign COUNT  = count_q;
  assign FULL   = (count_q == DEPTH_C);
  assign EMPTY  = (count_q == '0);
  assign AFULL  = (count_q >= AFULL_C);
  assign AEMPTY = (count_q <= AEMPTY_C);

  // Occupancy comes from count_q, so the pointer wrap bits carry no extra information.
  logic unused_wrap;
  assign unused_wrap = wptr_q[ADDRW] ^ rptr_q[ADDRW];

  generate
    if (FWFT != 0) begin : g_fwft
      assign R_DO = EMPTY ? '0 : mem_q[rptr_q[ADDRW-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] rdo_q;
      always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)       rdo_q <= '0;
        else if (rd_acc) rdo_q <= mem_q[rptr_q[ADDRW-1:0]];
      end
      assign R_DO = rdo_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Set has priority over clear when both happen on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (ERR_CLR) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (W_EN && FULL) ovf_d = 1'b1;
    if (REN && EMPTY) udf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: registered-read instance checked against a queue model,
// plus a FWFT instance; error flags exercised when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_sync_param;

  logic       CLK = 1'b0;
  logic       NRST = 1'b0;
  logic       w_en = 1'b0, ren = 1'b0;
  logic [7:0] w_di = '0;
  logic [7:0] r_do;
  logic       full, empty, afull, aempty;
  logic [4:0] count;

  logic       fw_wen = 1'b0, fw_ren = 1'b0;
  logic [7:0] fw_di = '0;
  logic [7:0] fw_rdo;
  logic       fw_full, fw_empty, fw_afull, fw_aempty;
  logic [4:0] fw_count;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf, udf, err_clr = 1'b0;
  logic fw_ovf, fw_udf, fw_err_clr = 1'b0;
`endif

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] last_rdo = '0;

  always #5 CLK = ~CLK;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut (
    .CLK(CLK), .NRST(NRST), .W_EN(w_en), .W_DI(w_di), .REN(ren), .R_DO(r_do),
    .FULL(full), .EMPTY(empty), .AFULL(afull), .AEMPTY(aempty), .COUNT(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .OVF(ovf), .UDF(udf), .ERR_CLR(err_clr)
`endif
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .CLK(CLK), .NRST(NRST), .W_EN(fw_wen), .W_DI(fw_di), .REN(fw_ren), .R_DO(fw_rdo),
    .FULL(fw_full), .EMPTY(fw_empty), .AFULL(fw_afull), .AEMPTY(fw_aempty), .COUNT(fw_count)
`ifdef FIFO_ERR_FLAGS_EN
    , .OVF(fw_ovf), .UDF(fw_udf), .ERR_CLR(fw_err_clr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One clock on the registered-read instance with the queue model tracking what should happen.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    bit         wa, ra;
    logic [7:0] e;
    int         n;
    n  = q.size();
    wa = w && (n < 16);
    ra = r && (n > 0);
    e  = ra ? q[0] : last_rdo;
    w_en = w; ren = r; w_di = d;
    step();
    w_en = 1'b0; ren = 1'b0;
    if (ra) begin
      void'(q.pop_front());
      last_rdo = e;
    end
    if (wa) q.push_back(d);
    n = q.size();
    check("count",  32'(count),  n);
    check("full",   32'(full),   32'(n == 16));
    check("empty",  32'(empty),  32'(n == 0));
    check("afull",  32'(afull),  32'(n >= 14));
    check("aempty", 32'(aempty), 32'(n <= 2));
    check("r_do",   32'(r_do),   32'(last_rdo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for two cycles, then released.
    NRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_count",  32'(count),  0);
    check("rst_empty",  32'(empty),  1);
    check("rst_aempty", 32'(aempty), 1);
    check("rst_full",   32'(full),   0);
    check("rst_afull",  32'(afull),  0);
    check("rst_rdo",    32'(r_do),   0);
    check("rst_fwrdo",  32'(fw_rdo), 0);
    NRST = 1'b1;
    step();
    check("idle_count", 32'(count),  0);
    check("idle_empty", 32'(empty),  1);

    // Fill to full, one dropped write, then drain plus one dropped read.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i * 37 + 11));
    cycle(1'b1, 1'b0, 8'hEE);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);

    // Wrap-around with interleaved traffic; pointers pass the 2*DEPTH boundary.
    for (int c = 0; c < 24; c++) cycle(1'b1, (c >= 4) && (c % 2 == 0), 8'(c * 13 + 5));
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle(1'b0, 1'b1, 8'h00);

    // Simultaneous read and write at COUNT=5.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'(8'h80 + i));
    for (int i = 0; i < 8 && q.size() > 0; i++) cycle(1'b0, 1'b1, 8'h00);

    // FWFT instance: data visible the cycle after the write, without REN.
    check("fw_empty0", 32'(fw_empty), 1);
    check("fw_rdo0",   32'(fw_rdo),   0);
    fw_di = 8'hA5; fw_wen = 1'b1;
    step();
    fw_wen = 1'b0;
    check("fw_rdo_a5",  32'(fw_rdo),   32'h A5);
    check("fw_empty_a", 32'(fw_empty), 0);
    check("fw_count1",  32'(fw_count), 1);
    step();
    check("fw_hold_a5", 32'(fw_rdo),   32'h A5);
    fw_ren = 1'b1;
    step();
    fw_ren = 1'b0;
    check("fw_empty_b", 32'(fw_empty), 1);
    check("fw_rdo_zero", 32'(fw_rdo),  0);
    fw_wen = 1'b1; fw_di = 8'h11;
    step();
    fw_di = 8'h22;
    step();
    fw_wen = 1'b0;
    check("fw_first",  32'(fw_rdo), 32'h11);
    fw_ren = 1'b1;
    step();
    fw_ren = 1'b0;
    check("fw_second", 32'(fw_rdo),   32'h22);
    check("fw_count",  32'(fw_count), 1);

`ifdef FIFO_ERR_FLAGS_EN
    check("udf_init", 32'(udf), 0);
    cycle(1'b0, 1'b1, 8'h00);
    check("udf_set", 32'(udf), 1);
    cycle(1'b0, 1'b0, 8'h00);
    check("udf_sticky", 32'(udf), 1);
    check("ovf_init",   32'(ovf), 0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    check("ovf_at_full", 32'(ovf), 0);
    cycle(1'b1, 1'b0, 8'hFF);
    check("ovf_set", 32'(ovf), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
    check("udf_clr", 32'(udf), 0);
    err_clr = 1'b1;
    cycle(1'b1, 1'b0, 8'h77);
    err_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf), 1);
    check("udf_clr2",     32'(udf), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
